// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller and its datapath.
//   - FSM state codes (2-bit binary, code 2'b11 is illegal)
//   - full-adder helper functions used by the datapath and the result capture
package serial_add_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    // Carry out of a full adder.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Sum bit of a full adder.
    function automatic logic sum_bit(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

endpackage

// File: rtl/serial_add_dp.sv
// Bit-serial adder datapath: two right-shift operand registers and a carry flop.
// The sum is shifted back into the top of SR_A while SR_B drains to zero.
// Ports:
//   CLK       rising-edge clock
//   Clear_b   asynchronous active-low reset
//   load      parallel load of both operands, clears carry (priority over shift)
//   shift     one serial add step per edge
//   A_in      operand A
//   B_in      operand B
//   sr_a      current SR_A contents
//   carry     current carry flop
//   sr_b_lsb  current SR_B[0], lets the controller see the step in progress
module serial_add_dp
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] sr_a,
    output logic             carry,
    output logic             sr_b_lsb
);

    logic [WIDTH-1:0] sr_a_q;
    logic [WIDTH-1:0] sr_b_q;
    logic             carry_q;

    logic [WIDTH-1:0] sr_a_step;
    logic [WIDTH-1:0] sr_b_step;
    logic             carry_step;

    always_comb begin
        sr_a_step  = {sum_bit(sr_a_q[0], sr_b_q[0], carry_q), sr_a_q[WIDTH-1:1]};
        sr_b_step  = {1'b0, sr_b_q[WIDTH-1:1]};
        carry_step = maj3(sr_a_q[0], sr_b_q[0], carry_q);
    end

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            sr_a_q  <= '0;
            sr_b_q  <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            sr_a_q  <= A_in;
            sr_b_q  <= B_in;
            carry_q <= 1'b0;
        end else if (shift) begin
            sr_a_q  <= sr_a_step;
            sr_b_q  <= sr_b_step;
            carry_q <= carry_step;
        end
    end

    assign sr_a     = sr_a_q;
    assign carry    = carry_q;
    assign sr_b_lsb = sr_b_q[0];

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencing controller for the bit-serial adder. Accepts an operand pair on a
// start/ready handshake, runs WIDTH shift steps, then presents {carry_out, sum}
// with a one-cycle done pulse. abort during SHIFT returns to IDLE without done.
// Ports:
//   CLK            rising-edge clock
//   Clear_b        asynchronous active-low reset
//   start          request, accepted only while ready
//   abort          synchronous cancel of an in-flight operation
//   A_in, B_in     operands, sampled on the accepting edge
//   ready          high in IDLE
//   busy           high in SHIFT
//   shift_control  shift enable to the datapath (equals busy)
//   done           one-cycle result-valid pulse
//   sum            registered result, held until the next done
//   carry_out      registered final carry, held with sum
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             ready,
    output logic             busy,
    output logic             shift_control,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;

    logic             load;
    logic             capture;

    logic [WIDTH-1:0] sr_a;
    logic             carry;
    logic             sr_b_lsb;

    // Result of the step taking place on this edge. Captured on the final
    // shift edge so sum is already valid during the DONE cycle.
    logic [WIDTH-1:0] sum_final;
    logic             carry_final;

    always_comb begin
        sum_final   = {sum_bit(sr_a[0], sr_b_lsb, carry), sr_a[WIDTH-1:1]};
        carry_final = maj3(sr_a[0], sr_b_lsb, carry);
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                count_d = count_q - CW'(1);
                // abort wins over the final shift: no capture, no done
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (count_q == CW'(1)) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                // illegal code 2'b11
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            state_q     <= IDLE;
            count_q     <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (capture) begin
                sum_q       <= sum_final;
                carry_out_q <= carry_final;
            end
        end
    end

    assign ready         = (state_q == IDLE);
    assign busy          = (state_q == SHIFT);
    assign shift_control = busy;
    assign done          = (state_q == DONE);
    assign sum           = sum_q;
    assign carry_out     = carry_out_q;

    serial_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .CLK      (CLK),
        .Clear_b  (Clear_b),
        .load     (load),
        .shift    (shift_control),
        .A_in     (A_in),
        .B_in     (B_in),
        .sr_a     (sr_a),
        .carry    (carry),
        .sr_b_lsb (sr_b_lsb)
    );

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl at WIDTH=4 and WIDTH=8.
// Reference: {carry_out, sum} = A + B, held across aborts; timing from the
// handshake rules (WIDTH busy cycles, one done cycle, WIDTH+2 start spacing).
module tb_serial_add_ctrl;

    logic       CLK = 1'b0;
    logic       Clear_b;
    logic       start4, start8, abort;
    logic [7:0] a_bus, b_bus;

    logic       ready4, busy4, shift4, done4, carry4;
    logic [3:0] sum4;
    logic       ready8, busy8, shift8, done8, carry8;
    logic [7:0] sum8;

    always #5 CLK = ~CLK;

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .CLK           (CLK),
        .Clear_b       (Clear_b),
        .start         (start4),
        .abort         (abort),
        .A_in          (a_bus[3:0]),
        .B_in          (b_bus[3:0]),
        .ready         (ready4),
        .busy          (busy4),
        .shift_control (shift4),
        .done          (done4),
        .sum           (sum4),
        .carry_out     (carry4)
    );

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .CLK           (CLK),
        .Clear_b       (Clear_b),
        .start         (start8),
        .abort         (abort),
        .A_in          (a_bus),
        .B_in          (b_bus),
        .ready         (ready8),
        .busy          (busy8),
        .shift_control (shift8),
        .done          (done8),
        .sum           (sum8),
        .carry_out     (carry8)
    );

    // Observation mux onto whichever instance is under test.
    logic       sel8;
    logic       o_ready, o_busy, o_shift, o_done;
    logic [8:0] o_res;
    assign o_ready = sel8 ? ready8 : ready4;
    assign o_busy  = sel8 ? busy8  : busy4;
    assign o_shift = sel8 ? shift8 : shift4;
    assign o_done  = sel8 ? done8  : done4;
    assign o_res   = sel8 ? {carry8, sum8} : {4'b0, carry4, sum4};

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [8:0]  res_model [2];   // last completed result per instance

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int g = 0;
        while (o_ready !== 1'b1 && g < 100) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 100) check_eq("ready_timeout", 32'(o_ready), 32'd1);
    endtask

    // One operation; abort_at=k raises abort before shift edge k (0 = none).
    task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                          input int abort_at);
        int         w;
        int         busy_n, done_n, shift_bad;
        logic [8:0] expv;
        logic [8:0] held;
        w = w8 ? 8 : 4;
        sel8 = w8;
        #1;
        if (w8) expv = {1'b0, a} + {1'b0, b};
        else    expv = {5'b0, a[3:0]} + {5'b0, b[3:0]};
        wait_ready();
        a_bus = a;
        b_bus = b;
        if (w8) start8 = 1'b1;
        else    start4 = 1'b1;
        @(negedge CLK);
        start4 = 1'b0;
        start8 = 1'b0;
        check_eq("ready_drop", 32'(o_ready), 32'd0);
        busy_n = 0;
        done_n = 0;
        shift_bad = 0;
        for (int k = 1; k <= w + 1; k++) begin
            if (o_busy) busy_n++;
            if (o_shift !== o_busy) shift_bad++;
            if (o_done) done_n++;
            a_bus = 8'($urandom);   // operands must already be captured
            b_bus = 8'($urandom);
            if (k == abort_at) abort = 1'b1;
            @(negedge CLK);
            abort = 1'b0;
            if (o_done) check_eq("result_at_done", 32'(o_res), 32'(expv));
        end
        if (abort_at == 0) res_model[w8] = expv;
        held = res_model[w8];
        check_eq("busy_cycles", busy_n, (abort_at == 0) ? w : abort_at);
        check_eq("done_cycles", done_n, (abort_at == 0) ? 1 : 0);
        check_eq("shift_eq_busy", shift_bad, 0);
        check_eq("ready_after", 32'(o_ready), 32'd1);
        check_eq("result_held", 32'(o_res), 32'(held));
    endtask

    initial begin
        int last, pulses, spacing_bad;
        Clear_b = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        abort = 1'b0;
        a_bus = '0;
        b_bus = '0;
        sel8 = 1'b0;
        res_model[0] = '0;
        res_model[1] = '0;
        #12;
        check_eq("rst_sum4", 32'({carry4, sum4}), 32'd0);
        check_eq("rst_sum8", 32'({carry8, sum8}), 32'd0);
        check_eq("rst_busy", 32'({busy4, busy8, done4, done8}), 32'd0);
        @(negedge CLK);
        Clear_b = 1'b1;
        @(negedge CLK);
        check_eq("rst_ready", 32'({ready4, ready8}), 32'd3);

        // Directed WIDTH=4 cases
        run_op(0, 8'd5, 8'd9, 0);
        run_op(0, 8'd15, 8'd1, 0);
        run_op(0, 8'd15, 8'd15, 0);

        // start held high: done every WIDTH+2 cycles
        sel8 = 1'b0;
        wait_ready();
        a_bus = 8'd3;
        b_bus = 8'd3;
        start4 = 1'b1;
        last = -1;
        pulses = 0;
        spacing_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (o_done) begin
                check_eq("b2b_sum", 32'(o_res), 32'd6);
                if (last >= 0 && i - last != 6) spacing_bad++;
                last = i;
                pulses++;
            end
        end
        start4 = 1'b0;
        check_eq("b2b_pulses", pulses, 3);
        check_eq("b2b_spacing", spacing_bad, 0);
        res_model[0] = 9'd6;   // operation in flight also uses 3+3

        // Abort on the 2nd shift edge and on the final shift edge
        run_op(0, 8'd7, 8'd7, 0);
        run_op(0, 8'd7, 8'd7, 2);
        run_op(0, 8'd3, 8'd8, 4);

        // Asynchronous reset mid-SHIFT
        wait_ready();
        a_bus = 8'd6;
        b_bus = 8'd5;
        start4 = 1'b1;
        @(negedge CLK);
        start4 = 1'b0;
        @(negedge CLK);
        #2;
        Clear_b = 1'b0;
        #1;
        check_eq("async_res", 32'(o_res), 32'd0);
        check_eq("async_busy", 32'({o_busy, o_done, o_shift}), 32'd0);
        res_model[0] = '0;
        res_model[1] = '0;
        @(negedge CLK);
        Clear_b = 1'b1;
        #1;
        check_eq("async_ready", 32'(o_ready), 32'd1);
        run_op(0, 8'd2, 8'd1, 0);

        // Random WIDTH=4 with occasional abort
        for (int i = 0; i < 12; i++) begin
            run_op(0, 8'($urandom), 8'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        // WIDTH=8
        run_op(1, 8'd200, 8'd100, 0);
        for (int i = 0; i < 6; i++) begin
            run_op(1, 8'($urandom), 8'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
